xbar_fifo_wr_arbiter: RTL and testbench

Round-robin arbiter sharing the write port of one asynchronous crossbar FIFO among N requesters in the FIFO's write-clock domain. Grants are burst-locked: once a requester wins, it keeps the port until it sends a beat flagged `last`. Stall is driven by the FIFO's `full` flag. The block muxes the winner's data onto the FIFO write bus.

---
 rtl/xbar_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 37 +++
 rtl/xbar_fifo_wr_arbiter.sv | 119 +++++++++++
 tb/tb_xbar_fifo_wr_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_arb_pkg.sv
// rtl/xbar_arb_pkg.sv - shared types and width helper for the crossbar FIFO write arbiter
package xbar_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector (double-width rotate + priority encode)
module rr_pick
    import xbar_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    localparam logic [IW:0] N_W = (IW+1)'(N);

    logic [N-1:0]  rot;
    logic [IW-1:0] off;
    logic [IW:0]   sum;

    always_comb begin
        rot   = N'({req, req} >> ptr);
        found = |rot;
        off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IW'(i);
            end
        end
        // Undo the rotation: offset is relative to ptr, modulo N
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        idx = sum[IW-1:0];
    end

endmodule

// File: rtl/xbar_fifo_wr_arbiter.sv
// rtl/xbar_fifo_wr_arbiter.sv - burst-locked round-robin arbiter for a shared FIFO write port
// Optional per-requester grant counters: XBAR_ARB_GRANT_CNT_EN
module xbar_fifo_wr_arbiter
    import xbar_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16,
    localparam int IW     = idx_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_wr_data,
    output logic [IW-1:0]             grant_idx,
    output logic                      busy
`ifdef XBAR_ARB_GRANT_CNT_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0]  grant_cnt
`endif
);

    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("NUM_REQ must be at least 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    arb_state_e    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          xfer;
    logic          xfer_last;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign xfer      = (state_q == BURST) & req_valid[grant_q] & ~fifo_full;
    assign xfer_last = xfer & req_last[grant_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BURST;
                    grant_d = pick_idx;
                end
            end
            BURST: begin
                // Grant is held through stalls and owner bubbles until a last beat moves
                if (xfer_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready    = '0;
        fifo_wr_en   = xfer;
        fifo_wr_data = '0;
        busy         = (state_q == BURST);
        grant_idx    = grant_q;
        if (xfer) begin
            req_ready[grant_q] = 1'b1;
            fifo_wr_data       = req_data[grant_q*DATA_W +: DATA_W];
        end
    end

`ifdef XBAR_ARB_GRANT_CNT_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q <= '0;
            end else if ((state_q == IDLE) && pick_found && (pick_idx == IW'(i))
                         && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        assign grant_cnt[i*CNT_W +: CNT_W] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_xbar_fifo_wr_arbiter.sv
// tb/tb_xbar_fifo_wr_arbiter.sv - scoreboard bench for xbar_fifo_wr_arbiter (optional XBAR_ARB_GRANT_CNT_EN)
module tb_xbar_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_wr_data;
    logic [1:0]      grant_idx;
    logic            busy;
`ifdef XBAR_ARB_GRANT_CNT_EN
    logic [N*CW-1:0] grant_cnt;
`endif

    xbar_fifo_wr_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (DW),
        .CNT_W   (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_idx    (grant_idx),
        .busy         (busy)
`ifdef XBAR_ARB_GRANT_CNT_EN
        ,
        .grant_cnt    (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [1:0]    idx;
        logic [DW-1:0] data;
    } exp_t;

    beat_t      rq [N][$];
    exp_t       sb [$];
    logic [N-1:0] accepted;
    logic [N-1:0] mute;
    logic       full_cmd;
    logic       prev_last;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic add_burst(input int r, input int n);
        logic [DW-1:0] d;
        for (int b = 0; b < n; b++) begin
            d = $urandom;
            rq[r].push_back('{data: d, last: (b == n - 1)});
            sb.push_back('{idx: 2'(r), data: d});
        end
    endtask

    function automatic int pending();
        int s = sb.size();
        for (int i = 0; i < N; i++) s += rq[i].size();
        return s;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (accepted[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        end
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                req_valid[i]          = ~mute[i];
                req_last[i]           = rq[i][0].last;
                req_data[i*DW +: DW]  = rq[i][0].data;
            end else begin
                req_valid[i]          = 1'b0;
                req_last[i]           = 1'b0;
                req_data[i*DW +: DW]  = '0;
            end
        end
        fifo_full = full_cmd;
    endtask

    task automatic monitor();
        exp_t e;
        logic was_last;
        accepted = req_ready;
        was_last = 1'b0;
        if (prev_last) check("bubble_after_last", 64'(busy), 64'(0));
        if (fifo_wr_en) begin
            if (sb.size() == 0) begin
                check("unexpected_wr", 64'(fifo_wr_en), 64'(0));
            end else begin
                e = sb.pop_front();
                check("wr_data", 64'(fifo_wr_data), 64'(e.data));
                check("wr_owner", 64'(grant_idx), 64'(e.idx));
                check("wr_ready", 64'(req_ready), 64'(4'b0001 << e.idx));
                was_last = req_last[e.idx];
            end
        end else begin
            check("idle_data", 64'(fifo_wr_data), 64'(0));
            check("idle_ready", 64'(req_ready), 64'(0));
        end
        prev_last = was_last;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        monitor();
    endtask

    task automatic drain(input int max_cycles);
        int c = 0;
        while (pending() > 0 && c < max_cycles) begin
            tick();
            c++;
        end
        check("drain_left", 64'(pending()), 64'(0));
    endtask

    task automatic wait_sb(input int target, input int max_cycles);
        int c = 0;
        while (sb.size() > target && c < max_cycles) begin
            tick();
            c++;
        end
        check("wait_sb", 64'(sb.size()), 64'(target));
    endtask

    task automatic clear_bench();
        for (int i = 0; i < N; i++) rq[i].delete();
        sb.delete();
        accepted  = '0;
        mute      = '0;
        prev_last = 1'b0;
        full_cmd  = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        clear_bench();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_wr_en", 64'(fifo_wr_en), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_data", 64'(fifo_wr_data), 64'(0));
        check("rst_grant", 64'(grant_idx), 64'(0));
        rst = 1'b1;
        tick();

        // Round robin with single-beat bursts, plus first-burst latency
        for (int rep = 0; rep < 2; rep++)
            for (int r = 0; r < N; r++) add_burst(r, 1);
        tick();
        check("lat_arb_busy", 64'(busy), 64'(0));
        check("lat_arb_wr", 64'(fifo_wr_en), 64'(0));
        tick();
        check("lat_first_busy", 64'(busy), 64'(1));
        check("lat_first_wr", 64'(fifo_wr_en), 64'(1));
        drain(100);

        // Burst lock: req1 waits behind a 3-beat burst from req0
        add_burst(0, 3);
        add_burst(1, 1);
        drain(50);

        // Full stall mid-burst on req2
        add_burst(2, 4);
        wait_sb(2, 20);
        full_cmd = 1'b1;
        repeat (5) begin
            tick();
            check("full_wr_en", 64'(fifo_wr_en), 64'(0));
            check("full_ready", 64'(req_ready), 64'(0));
            check("full_busy", 64'(busy), 64'(1));
            check("full_grant", 64'(grant_idx), 64'(2));
        end
        full_cmd = 1'b0;
        drain(50);

        // Owner 3 bubbles, then wrap: req0 must beat req2
        add_burst(3, 2);
        add_burst(0, 1);
        add_burst(2, 1);
        wait_sb(3, 20);
        mute[3] = 1'b1;
        repeat (2) begin
            tick();
            check("bubble_wr_en", 64'(fifo_wr_en), 64'(0));
            check("bubble_busy", 64'(busy), 64'(1));
            check("bubble_grant", 64'(grant_idx), 64'(3));
        end
        mute[3] = 1'b0;
        drain(50);

        // Asynchronous reset in the middle of an active burst
        add_burst(0, 3);
        wait_sb(2, 20);
        check("pre_rst_wr_en", 64'(fifo_wr_en), 64'(1));
        rst = 1'b0;
        #1;
        check("mid_rst_wr_en", 64'(fifo_wr_en), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_ready", 64'(req_ready), 64'(0));
        check("mid_rst_data", 64'(fifo_wr_data), 64'(0));
        check("mid_rst_grant", 64'(grant_idx), 64'(0));
        clear_bench();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_busy", 64'(busy), 64'(0));
        check("post_rst_grant", 64'(grant_idx), 64'(0));
        // rr_ptr back at 0: req1 must win before req3
        add_burst(1, 1);
        add_burst(3, 1);
        drain(50);

`ifdef XBAR_ARB_GRANT_CNT_EN
        rst = 1'b0;
        clear_bench();
        tick();
        rst = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) add_burst(1, 1);
        drain(100);
        for (int i = 0; i < N; i++) begin
            check($sformatf("grant_cnt%0d", i), 64'(grant_cnt[i*CW +: CW]),
                  (i == 1) ? 64'(3) : 64'(0));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
